reg_serial_tx: RTL and testbench



---
 rtl/reg_link_pkg.sv | 13 +
 rtl/sclk_tick_gen.sv | 37 +++
 rtl/reg_serial_tx.sv | 130 +++++++++++++
 tb/tb_reg_serial_tx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_link_pkg.sv
// rtl/reg_link_pkg.sv - state encoding and default frame geometry shared by the register read-out link
package reg_link_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } link_state_t;

  localparam int LINK_WIDTH   = 15;
  localparam int LINK_CLK_DIV = 4;

endpackage

// File: rtl/sclk_tick_gen.sv
// rtl/sclk_tick_gen.sv - sclk half-period divider producing a toggle strobe and its direction
module sclk_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  input  logic sclk,
  output logic tick,
  output logic tick_fall
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (clear) begin
      div_cnt <= '0;
    end else if (enable) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  assign tick = enable && (div_cnt == DIV_LAST);
  // sclk still holds its pre-toggle level, so a tick while high is the falling toggle
  assign tick_fall = tick && sclk;

endmodule

// File: rtl/reg_serial_tx.sv
// rtl/reg_serial_tx.sv - captures a register word and shifts it out MSB-first on sclk/sdata/frame_n
module reg_serial_tx
  import reg_link_pkg::*;
#(
  parameter int WIDTH   = LINK_WIDTH,
  parameter int CLK_DIV = LINK_CLK_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic             sclk,
  output logic             sdata,
  output logic             frame_n
);

  localparam int BIT_W = $clog2(WIDTH);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  link_state_t      state;
  link_state_t      next_state;
  logic [WIDTH-1:0] shreg;
  logic [BIT_W-1:0] bit_cnt;
  logic             accept;
  logic             tick;
  logic             tick_fall;
  logic             last_fall;
  logic             busy_d;
  logic             done_d;
  logic             frame_n_d;

  assign accept    = (state == IDLE) && start;
  assign last_fall = tick_fall && (bit_cnt == BIT_LAST);

  sclk_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk      (clk),
    .reset    (reset),
    .enable   (state == SHIFT),
    .clear    (accept),
    .sclk     (sclk),
    .tick     (tick),
    .tick_fall(tick_fall)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = start ? SHIFT : IDLE;
      SHIFT:   next_state = last_fall ? DONE : SHIFT;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Decoded from next_state so the flops below hold the values for the coming cycle
  always_comb begin
    busy_d    = 1'b0;
    done_d    = 1'b0;
    frame_n_d = 1'b1;
    case (next_state)
      SHIFT: begin
        busy_d    = 1'b1;
        frame_n_d = 1'b0;
      end
      DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: begin
        busy_d    = 1'b0;
        done_d    = 1'b0;
        frame_n_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      frame_n <= 1'b1;
    end else begin
      busy    <= busy_d;
      done    <= done_d;
      frame_n <= frame_n_d;
    end
  end

  // sdata is the shift register MSB; clearing shreg outside SHIFT keeps the line low when idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
    end else if (accept) begin
      shreg   <= data_in;
      bit_cnt <= '0;
      sclk    <= 1'b0;
    end else if (state == SHIFT) begin
      if (last_fall) begin
        shreg <= '0;
        sclk  <= 1'b0;
      end else if (tick_fall) begin
        shreg   <= {shreg[WIDTH-2:0], 1'b0};
        bit_cnt <= bit_cnt + 1'b1;
        sclk    <= 1'b0;
      end else if (tick) begin
        sclk <= 1'b1;
      end
    end else begin
      shreg <= '0;
      sclk  <= 1'b0;
    end
  end

  assign sdata = shreg[WIDTH-1];

endmodule

// File: tb/tb_reg_serial_tx.sv
// tb/tb_reg_serial_tx.sv - scoreboard bench for reg_serial_tx against a frame-level link model
module tb_reg_serial_tx;
  import reg_link_pkg::*;

  localparam int W     = LINK_WIDTH;
  localparam int D     = LINK_CLK_DIV;
  localparam int FRAME = 2 * D * W;

  logic         clk     = 1'b0;
  logic         reset   = 1'b1;
  logic         start   = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         busy, done, sclk, sdata, frame_n;
  logic         start_m = 1'b0;
  logic [1:0]   data_m  = '0;
  logic         busy_m, done_m, sclk_m, sdata_m, frame_n_m;

  int n_checks   = 0;
  int n_pass     = 0;
  int edge_n     = 0;
  int model_free = 0;
  int n_accepts  = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w;

  bit in_frame  = 0;
  bit post_done = 0;
  bit prev_sclk = 0;
  int t_frame, first_rise, last_rise, n_bits, n_space_bad, n_busy_bad, n_done_bad;
  int gap       = 0;
  int last_gap  = 0;
  logic [W-1:0] rx_word;

  always #5 clk = ~clk;

  reg_serial_tx dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in),
    .busy(busy), .done(done), .sclk(sclk), .sdata(sdata), .frame_n(frame_n)
  );

  reg_serial_tx #(.WIDTH(2), .CLK_DIV(1)) dut_min (
    .clk(clk), .reset(reset), .start(start_m), .data_in(data_m),
    .busy(busy_m), .done(done_m), .sclk(sclk_m), .sdata(sdata_m), .frame_n(frame_n_m)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  // A frame occupies the link for FRAME cycles plus DONE, and start is only seen once back in IDLE
  task automatic drive(input logic s, input logic [W-1:0] d);
    start   = s;
    data_in = d;
    if (s && !reset && edge_n >= model_free) begin
      exp_q.push_back(d);
      n_accepts++;
      model_free = edge_n + FRAME + 2;
    end
    @(posedge clk);
    edge_n++;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || in_frame) && n < budget) begin
      drive(1'b0, '0);
      n++;
    end
    check("wait_idle_timeout", 32'(n < budget), 32'd1);
    repeat (3) drive(1'b0, '0);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      in_frame  = 0;
      post_done = 0;
      gap       = 0;
      prev_sclk = 0;
    end else begin
      if (post_done) begin
        check("done_one_cycle", 32'({done, busy}), 32'd0);
        post_done = 0;
      end
      if (!in_frame && !frame_n) begin
        in_frame    = 1;
        last_gap    = gap;
        gap         = 0;
        t_frame     = 0;
        n_bits      = 0;
        rx_word     = '0;
        first_rise  = -1;
        last_rise   = 0;
        n_space_bad = 0;
        n_busy_bad  = 0;
        n_done_bad  = 0;
      end
      if (in_frame && frame_n) begin
        check("frame_len", t_frame, FRAME);
        check("end_done_busy_sclk_sdata", 32'({done, busy, sclk, sdata}), 32'b1100);
        check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          exp_w = exp_q.pop_front();
          check("frame_word", 32'(rx_word), 32'(exp_w));
        end
        check("bit_count", n_bits, W);
        check("first_rise", first_rise, D);
        check("rise_spacing_bad", n_space_bad, 0);
        check("busy_low_in_frame", n_busy_bad, 0);
        check("done_early", n_done_bad, 0);
        in_frame  = 0;
        post_done = 1;
        gap       = 1;
      end else if (in_frame) begin
        if (sclk && !prev_sclk) begin
          if (n_bits == 0) first_rise = t_frame;
          else if (t_frame - last_rise != 2 * D) n_space_bad++;
          last_rise = t_frame;
          rx_word   = {rx_word[W-2:0], sdata};
          n_bits++;
        end
        if (!busy) n_busy_bad++;
        if (done) n_done_bad++;
        t_frame++;
      end else if (frame_n) begin
        gap++;
      end
      prev_sclk = sclk;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n0;
    int guard;
    logic [5:0] sclk_tr, busy_tr, frame_tr;
    logic [1:0] rx_m;
    int rises_m, done_idx, done_cnt;
    bit prev_m;

    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({busy, done, sclk, sdata, frame_n}), 32'b00001);
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_outputs", 32'({busy, done, sclk, sdata, frame_n}), 32'b00001);
    end
    check("idle_outputs_min", 32'({busy_m, done_m, sclk_m, sdata_m, frame_n_m}), 32'b00001);

    // single frame, with a rejected start at k+10 and data_in churning throughout
    drive(1'b1, 15'h5A3C);
    for (int i = 1; i <= 125; i++) drive(i == 10, (i == 10) ? 15'h7FFF : W'($urandom));
    wait_idle(300);

    // start held high across two frames
    n0    = n_accepts;
    guard = 0;
    while (n_accepts < n0 + 2 && guard < 400) begin
      drive(1'b1, (n_accepts == n0) ? 15'h0001 : 15'h4000);
      guard++;
    end
    wait_idle(400);
    check("b2b_gap", last_gap, 2);

    for (int i = 0; i < 1500; i++) drive($urandom_range(0, 15) == 0, W'($urandom));
    wait_idle(300);

    // asynchronous reset in the middle of a frame
    drive(1'b1, 15'h2D6B);
    repeat (36) drive(1'b0, '0);
    @(posedge clk);
    edge_n++;
    #2 reset = 1'b1;
    #1 check("reset_async", 32'({busy, done, sclk, sdata, frame_n}), 32'b00001);
    exp_q.delete();
    model_free = 0;
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    drive(1'b1, W'($urandom));
    wait_idle(300);

    // WIDTH=2, CLK_DIV=1 instance
    start_m = 1'b1;
    data_m  = 2'b10;
    @(posedge clk);
    #1 start_m = 1'b0;
    rx_m     = '0;
    rises_m  = 0;
    done_idx = -1;
    done_cnt = 0;
    prev_m   = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sclk_tr[i]  = sclk_m;
      busy_tr[i]  = busy_m;
      frame_tr[i] = frame_n_m;
      if (sclk_m && !prev_m) begin
        rx_m = {rx_m[0], sdata_m};
        rises_m++;
      end
      if (done_m) begin
        done_idx = i;
        done_cnt++;
      end
      prev_m = sclk_m;
    end
    check("min_sclk_trace", 32'(sclk_tr), 32'b001010);
    check("min_busy_trace", 32'(busy_tr), 32'b011111);
    check("min_frame_n_trace", 32'(frame_tr), 32'b110000);
    check("min_rx_bits", 32'(rx_m), 32'b10);
    check("min_rises", rises_m, 2);
    check("min_done_idx", done_idx, 4);
    check("min_done_count", done_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
